// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map constants, target/state enums and address decode
//
// Shared by the bus controller: default window bases, the access target
// enumeration, the controller state enumeration and the decode function.
package mem_map_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT  = 16'h6000;
    localparam logic [15:0] ROM_BASE_DEFAULT = 16'h8000;

    typedef enum logic [1:0] {
        TGT_RAM = 2'd0,
        TGT_IO  = 2'd1,
        TGT_ROM = 2'd2
    } target_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    // ROM wins above rom_base, IO between the two bases, RAM below io_base.
    function automatic target_e decode(input logic [15:0] addr,
                                       input logic [15:0] io_base,
                                       input logic [15:0] rom_base);
        if (addr >= rom_base) begin
            return TGT_ROM;
        end else if (addr >= io_base) begin
            return TGT_IO;
        end else begin
            return TGT_RAM;
        end
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - 6502 memory port to RAM/IO/ROM bus controller
//
// Accepts one CPU access at a time, decodes it to RAM, IO or ROM, drives the
// target address/data/strobes from registers, waits out the target's read
// latency and returns read data with a one-cycle cpu_ack.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_req/cpu_addr/cpu_we/cpu_wdata CPU request (held until cpu_ack)
//   cpu_ack/cpu_rdata                 completion pulse and read data
//   rom_addr/rom_data                 ROM address out, registered data in
//   ram_addr/ram_we/ram_wdata/ram_rdata RAM port
//   io_addr/io_we/io_re/io_wdata/io_rdata IO port (address is offset from IO_BASE)
//   rom_wr_err                        sticky: a write hit the ROM window
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter logic [15:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter logic [15:0] ROM_BASE = ROM_BASE_DEFAULT,
    parameter int unsigned ROM_LAT  = 1,
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned IO_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [12:0] io_addr,
    output logic        io_we,
    output logic        io_re,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    output logic        rom_wr_err
);

    localparam logic [1:0] ROM_LAT_C = 2'(ROM_LAT);
    localparam logic [1:0] RAM_LAT_C = 2'(RAM_LAT);
    localparam logic [1:0] IO_LAT_C  = 2'(IO_LAT);

    bus_state_e state;
    logic [1:0] wait_cnt;
    logic [1:0] lat_q;      // WAIT cycles beyond the first for this access
    target_e    tgt_q;
    logic       we_q;

    logic       accept;
    target_e    dec_tgt;
    logic [12:0] io_off;
    logic [1:0] lat_new;

    assign accept  = cpu_req && ((state == IDLE) || (state == RESP));
    assign dec_tgt = decode(cpu_addr, IO_BASE, ROM_BASE);
    assign io_off  = 13'(cpu_addr - IO_BASE);

    // Writes complete after a single WAIT cycle, so they use latency 0.
    always_comb begin
        lat_new = 2'd0;
        if (!cpu_we) begin
            case (dec_tgt)
                TGT_ROM: lat_new = ROM_LAT_C;
                TGT_IO:  lat_new = IO_LAT_C;
                default: lat_new = RAM_LAT_C;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            lat_q      <= 2'd0;
            tgt_q      <= TGT_RAM;
            we_q       <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= 8'h00;
            rom_addr   <= 15'd0;
            ram_addr   <= 15'd0;
            io_addr    <= 13'd0;
            ram_wdata  <= 8'h00;
            io_wdata   <= 8'h00;
            ram_we     <= 1'b0;
            io_we      <= 1'b0;
            io_re      <= 1'b0;
            rom_wr_err <= 1'b0;
        end else begin
            ram_we  <= 1'b0;
            io_we   <= 1'b0;
            io_re   <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state     <= WAIT;
                        wait_cnt  <= 2'd0;
                        lat_q     <= lat_new;
                        tgt_q     <= dec_tgt;
                        we_q      <= cpu_we;
                        // All target ports see the same latched address.
                        rom_addr  <= cpu_addr[14:0];
                        ram_addr  <= cpu_addr[14:0];
                        io_addr   <= io_off;
                        ram_wdata <= cpu_wdata;
                        io_wdata  <= cpu_wdata;
                        ram_we    <= cpu_we && (dec_tgt == TGT_RAM);
                        io_we     <= cpu_we && (dec_tgt == TGT_IO);
                        io_re     <= !cpu_we && (dec_tgt == TGT_IO);
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == lat_q) begin
                        state   <= RESP;
                        cpu_ack <= 1'b1;
                        if (we_q) begin
                            if (tgt_q == TGT_ROM) begin
                                rom_wr_err <= 1'b1;
                            end
                        end else begin
                            case (tgt_q)
                                TGT_ROM: cpu_rdata <= rom_data;
                                TGT_IO:  cpu_rdata <= io_rdata;
                                default: cpu_rdata <= ram_rdata;
                            endcase
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

    localparam int NCYC = 4096;
    localparam int BIG  = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data = 8'h0;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h0;
    logic [12:0] io_addr;
    logic        io_we;
    logic        io_re;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata = 8'h0;
    logic        rom_wr_err;

    mem_bus_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_addr(io_addr), .io_we(io_we), .io_re(io_re), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .rom_wr_err(rom_wr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Target memories: ROM/RAM one registered stage, IO two stages.
    logic [7:0] rom_mem [0:32767];
    logic [7:0] ram_mem [0:32767];
    logic [7:0] io_mem  [0:8191];
    logic [7:0] io_p1 = 8'h0;

    always @(posedge clk) begin
        rom_data  <= rom_mem[rom_addr];
        ram_rdata <= ram_mem[ram_addr];
        io_p1     <= io_mem[io_addr];
        io_rdata  <= io_p1;
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (io_we)  io_mem[io_addr]   <= io_wdata;
    end

    // Reference contents as the CPU intends them to be.
    logic [7:0] ref_ram [0:32767];
    logic [7:0] ref_io  [0:8191];

    // Per-cycle expectations, indexed by the edge count just elapsed.
    bit       exp_ack  [NCYC];
    bit       exp_rdv  [NCYC];
    bit [7:0] exp_rd   [NCYC];
    bit       exp_ramwe[NCYC];
    bit       exp_iowe [NCYC];
    bit       exp_iore [NCYC];
    int       err_cyc = BIG;
    logic [7:0] m_rdata = 8'h0;
    int       ack_hist[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_rdata = 8'h00;
            chk("rst_ack", 32'(cpu_ack), 0);
            chk("rst_rdata", 32'(cpu_rdata), 0);
            chk("rst_strobes", {29'd0, ram_we, io_we, io_re}, 0);
            chk("rst_err", 32'(rom_wr_err), 0);
            chk("rst_addr", {2'd0, rom_addr} | {2'd0, ram_addr} | {4'd0, io_addr}, 0);
            chk("rst_wdata", {16'd0, ram_wdata, io_wdata}, 0);
        end else if (cyc < NCYC) begin
            if (exp_ack[cyc] && exp_rdv[cyc]) m_rdata = exp_rd[cyc];
            chk("ack", 32'(cpu_ack), 32'(exp_ack[cyc]));
            chk("rdata", 32'(cpu_rdata), 32'(m_rdata));
            chk("ram_we", 32'(ram_we), 32'(exp_ramwe[cyc]));
            chk("io_we", 32'(io_we), 32'(exp_iowe[cyc]));
            chk("io_re", 32'(io_re), 32'(exp_iore[cyc]));
            chk("rom_wr_err", 32'(rom_wr_err), 32'(cyc >= err_cyc));
            if (cpu_ack) ack_hist.push_back(cyc);
        end
    end

    function automatic int last_ack();
        return (ack_hist.size() > 0) ? ack_hist[$] : -1;
    endfunction

    // Issue one access starting at a negedge; returns in the ack cycle (+1).
    task automatic access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                          input bit b2b, output int acc_e);
        int e, lat, ack_c;
        logic [15:0] off;
        bit is_rom, is_io;
        e      = cyc + 1;
        acc_e  = e;
        is_rom = (a >= 16'h8000);
        is_io  = !is_rom && (a >= 16'h6000);
        off    = a - 16'h6000;
        lat    = we ? 0 : (is_io ? 2 : 1);
        ack_c  = e + lat + 1;
        cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
        if (we) begin
            if (is_rom) begin
                if (err_cyc > e + 1) err_cyc = e + 1;
            end else if (is_io) begin
                exp_iowe[e] = 1'b1;
                ref_io[off[12:0]] = wd;
            end else begin
                exp_ramwe[e] = 1'b1;
                ref_ram[a[14:0]] = wd;
            end
        end else begin
            if (is_io) exp_iore[e] = 1'b1;
            exp_rdv[ack_c] = 1'b1;
            exp_rd[ack_c]  = is_rom ? rom_mem[a[14:0]] : (is_io ? ref_io[off[12:0]] : ref_ram[a[14:0]]);
        end
        exp_ack[ack_c] = 1'b1;
        @(negedge clk);
        chk("rom_addr", 32'(rom_addr), 32'(a[14:0]));
        chk("ram_addr", 32'(ram_addr), 32'(a[14:0]));
        chk("io_addr", 32'(io_addr), 32'(off[12:0]));
        while (cyc < ack_c) @(negedge clk);
        if (!b2b) cpu_req = 1'b0;
        #1;
    endtask

    int e0, e1, e2, n0;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            rom_mem[i] = 8'(i * 7 + 3);
            ram_mem[i] = 8'h00;
            ref_ram[i] = 8'h00;
        end
        for (int i = 0; i < 8192; i++) begin
            io_mem[i] = 8'h00;
            ref_io[i] = 8'h00;
        end
        rom_mem[15'h1234] = 8'hA9;
        rom_mem[15'h0000] = 8'h11;
        rom_mem[15'h0001] = 8'h22;
        rom_mem[15'h7FFF] = 8'h33;
        rom_mem[15'h0100] = 8'hC3;
        io_mem[13'h0010]  = 8'h5A;
        ref_io[13'h0010]  = 8'h5A;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // ROM read, latency 1: ack two cycles past the accept edge
        access(16'h9234, 1'b0, 8'h00, 1'b0, e0);
        chk("rom_rd_data", 32'(cpu_rdata), 32'hA9);
        chk("rom_rd_lat", 32'(last_ack() - e0), 2);
        @(negedge clk);
        #1 chk("rom_ack_width", 32'(cpu_ack), 0);

        // RAM write then read-back
        access(16'h0200, 1'b1, 8'h55, 1'b0, e0);
        chk("ram_wr_lat", 32'(last_ack() - e0), 1);
        access(16'h0200, 1'b0, 8'h00, 1'b0, e0);
        chk("ram_rd_data", 32'(cpu_rdata), 32'h55);

        // IO read with latency 2, IO write and read-back
        access(16'h6010, 1'b0, 8'h00, 1'b0, e0);
        chk("io_rd_data", 32'(cpu_rdata), 32'h5A);
        chk("io_rd_lat", 32'(last_ack() - e0), 3);
        access(16'h6020, 1'b1, 8'h77, 1'b0, e0);
        access(16'h6020, 1'b0, 8'h00, 1'b0, e0);
        chk("io_wr_rd", 32'(cpu_rdata), 32'h77);

        // Window boundaries
        access(16'h5FFF, 1'b1, 8'h66, 1'b0, e0);
        access(16'h5FFF, 1'b0, 8'h00, 1'b0, e0);
        chk("ram_top_rd", 32'(cpu_rdata), 32'h66);
        access(16'h6000, 1'b0, 8'h00, 1'b0, e0);

        // Back-to-back ROM reads with cpu_req held
        n0 = ack_hist.size();
        access(16'h8000, 1'b0, 8'h00, 1'b1, e0);
        chk("b2b_d0", 32'(cpu_rdata), 32'h11);
        access(16'h8001, 1'b0, 8'h00, 1'b1, e1);
        chk("b2b_d1", 32'(cpu_rdata), 32'h22);
        access(16'hFFFF, 1'b0, 8'h00, 1'b0, e2);
        chk("b2b_d2", 32'(cpu_rdata), 32'h33);
        chk("b2b_count", 32'(ack_hist.size() - n0), 3);
        if (ack_hist.size() >= n0 + 3) begin
            chk("b2b_space1", 32'(ack_hist[n0 + 1] - ack_hist[n0]), 3);
            chk("b2b_space2", 32'(ack_hist[n0 + 2] - ack_hist[n0 + 1]), 3);
        end

        // ROM write: no strobes, ack after one clock, sticky error
        access(16'hC000, 1'b1, 8'h00, 1'b0, e0);
        chk("rom_wr_lat", 32'(last_ack() - e0), 1);
        chk("rom_wr_err_set", 32'(rom_wr_err), 1);
        chk("rom_wr_rdata_kept", 32'(cpu_rdata), 32'h33);
        access(16'h0010, 1'b0, 8'h00, 1'b0, e0);
        chk("rom_wr_err_sticky", 32'(rom_wr_err), 1);

        // Reset in the middle of a ROM read
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 16'h8100; cpu_we = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        cpu_req = 1'b0;
        err_cyc = BIG;
        #1 chk("rstmid_ack", 32'(cpu_ack), 0);
        chk("rstmid_err", 32'(rom_wr_err), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        access(16'h8100, 1'b0, 8'h00, 1'b0, e0);
        chk("post_rst_data", 32'(cpu_rdata), 32'hC3);
        chk("post_rst_lat", 32'(last_ack() - e0), 2);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
